// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder/subtractor: state encoding,
// default width and the bit-counter width helper.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Bits needed to count 0..width-1, never less than one.
    function automatic int cnt_w(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/response bundle of the serial adder: operands and start in,
// busy/done handshake and registered results out.
interface serial_adder_if #(
    parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
) ();

    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, op_sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, op_sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );

endinterface

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder assembled from two half adders; the serial datapath
// uses a single instance of it.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.a(a),  .b(b),   .sum(s0),  .carry(c0));
    half_adder u_ha1 (.a(s0), .b(cin), .sum(sum), .carry(c1));

    // The two half-adder carries can never both be set, so OR is exact.
    assign carry = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor: one bit per clock through a single
// full adder and a carry flop, with a start/busy/done handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);

    localparam int              CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] res_shift;

    full_adder u_fa (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .cin   (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // New bit enters at the MSB; after WIDTH shifts bit 0 sits at position 0.
    assign res_shift = (res_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    always_comb begin
        // NOTE: every next-state value gets a default first, so no path through the case infers a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.op_sub ? ~bus.b : bus.b;
                    carry_d = bus.op_sub ? 1'b1 : bus.cin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = res_shift;
                carry_d = fa_carry;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // carry_q is the carry into the MSB on this last bit.
                    sum_d   = res_shift;
                    cout_d  = fa_carry;
                    ovf_d   = carry_q ^ fa_carry;
                    state_d = DONE;
                end
            end

            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8, 1 and 16: directed table,
// handshake/reset sequences and a random sweep against an arithmetic model.
module tb_serial_adder;

    logic        clk;
    logic        rst;
    logic        start_r;
    int          sel_r;
    logic        op_r;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic        cin_r;

    int n_vec;
    int n_err;

    serial_adder_if #(.WIDTH(8))  if8  ();
    serial_adder_if #(.WIDTH(1))  if1  ();
    serial_adder_if #(.WIDTH(16)) if16 ();

    serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
    serial_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
    serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

    assign if8.start  = start_r && (sel_r == 8);
    assign if8.op_sub = op_r;
    assign if8.a      = a_r[7:0];
    assign if8.b      = b_r[7:0];
    assign if8.cin    = cin_r;

    assign if1.start  = start_r && (sel_r == 1);
    assign if1.op_sub = op_r;
    assign if1.a      = a_r[0:0];
    assign if1.b      = b_r[0:0];
    assign if1.cin    = cin_r;

    assign if16.start  = start_r && (sel_r == 16);
    assign if16.op_sub = op_r;
    assign if16.a      = a_r;
    assign if16.b      = b_r;
    assign if16.cin    = cin_r;

    // Outputs of whichever instance the current test is driving.
    logic        d_busy, d_done, d_cout, d_ovf;
    logic [15:0] d_sum;
    always_comb begin
        d_busy = if8.busy; d_done = if8.done; d_sum = 16'(if8.sum);
        d_cout = if8.cout; d_ovf  = if8.ovf;
        if (sel_r == 1) begin
            d_busy = if1.busy; d_done = if1.done; d_sum = 16'(if1.sum);
            d_cout = if1.cout; d_ovf  = if1.ovf;
        end else if (sel_r == 16) begin
            d_busy = if16.busy; d_done = if16.done; d_sum = if16.sum;
            d_cout = if16.cout; d_ovf  = if16.ovf;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain modular and signed arithmetic on w-bit operands.
    task automatic ref_model(input int w, input logic op, input logic [15:0] a, input logic [15:0] b,
                             input logic c, output logic [15:0] s, output logic co, output logic ov);
        longint mask, ua, ub, full, sa, sb, r, half;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        if (op) begin
            full = (ua - ub) & mask;
            co   = (ua >= ub);
        end else begin
            full = ua + ub + longint'(c);
            co   = ((full >> w) & 1) != 0;
        end
        s  = 16'(full & mask);
        sa = (ua >= half) ? ua - (mask + 1) : ua;
        sb = (ub >= half) ? ub - (mask + 1) : ub;
        r  = op ? sa - sb : sa + sb + longint'(c);
        ov = (r > half - 1) || (r < -half);
    endtask

    // Starts one operation from IDLE at a negedge and waits (bounded) for done.
    task automatic run_op(input int sel, input logic op, input logic [15:0] av, input logic [15:0] bv,
                          input logic c, output logic [15:0] s, output logic co, output logic ov,
                          output int lat, output int busy_cnt);
        sel_r   = sel;
        op_r    = op;
        a_r     = av;
        b_r     = bv;
        cin_r   = c;
        start_r = 1'b1;
        busy_cnt = 0;
        @(negedge clk);
        start_r = 1'b0;
        lat = 1;
        while (!d_done && lat < 100) begin
            if (d_busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) check("done timeout", 64'(lat), 64'd0);
        s  = d_sum;
        co = d_cout;
        ov = d_ovf;
        @(negedge clk);
        check("done pulse width", 64'(d_done), 64'd0);
    endtask

    typedef struct {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [15:0] s, es;
        logic        co, ov, eco, eov;
        int          lat, bc, n_done, last_i;

        n_vec = 0; n_err = 0;
        rst = 1'b1; start_r = 1'b0; sel_r = 8;
        op_r = 1'b0; a_r = '0; b_r = '0; cin_r = 1'b0;

        tbl[0] = '{1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 8'h07, 8'h07, 1'b0, 8'h00, 1'b1, 1'b0};

        #12;
        check("reset busy", 64'(if8.busy), 64'd0);
        check("reset done", 64'(if8.done), 64'd0);
        check("reset sum",  64'(if8.sum),  64'd0);
        check("reset cout", 64'(if8.cout), 64'd0);
        check("reset ovf",  64'(if8.ovf),  64'd0);
        check("reset sum16", 64'(if16.sum), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_op(8, tbl[i].op, 16'(tbl[i].a), 16'(tbl[i].b), tbl[i].cin, s, co, ov, lat, bc);
            check($sformatf("tbl%0d sum", i),  64'(s),  64'(tbl[i].sum));
            check($sformatf("tbl%0d cout", i), 64'(co), 64'(tbl[i].cout));
            check($sformatf("tbl%0d ovf", i),  64'(ov), 64'(tbl[i].ovf));
            check($sformatf("tbl%0d latency", i), 64'(lat), 64'd9);
            check($sformatf("tbl%0d busy cycles", i), 64'(bc), 64'd8);
        end

        // start held high: one done every WIDTH+2 cycles, nothing queued.
        sel_r = 8; op_r = 1'b0; a_r = 16'd3; b_r = 16'd4; cin_r = 1'b0;
        start_r = 1'b1;
        n_done = 0; last_i = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (d_done) begin
                n_done++;
                check("held sum", 64'(d_sum), 64'h07);
                if (last_i > 0) check("held spacing", 64'(i - last_i), 64'd10);
                last_i = i;
            end
        end
        start_r = 1'b0;
        check("held done count", 64'(n_done), 64'd3);

        // Operands changing mid-RUN must not disturb the captured ones.
        a_r = 16'd3; b_r = 16'd4; start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        repeat (3) @(negedge clk);
        a_r = 16'h10; b_r = 16'hFF;
        lat = 0;
        while (!d_done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("midrun change sum", 64'(d_sum), 64'h07);
        check("midrun change latency", 64'(lat), 64'd5);
        @(negedge clk);

        // Asynchronous reset in the middle of RUN.
        a_r = 16'h0F; b_r = 16'h01; start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort busy", 64'(d_busy), 64'd0);
        check("abort done", 64'(d_done), 64'd0);
        check("abort sum",  64'(d_sum),  64'd0);
        check("abort cout", 64'(d_cout), 64'd0);
        #1 rst = 1'b0;
        n_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (d_done) n_done++;
        end
        check("abort no done", 64'(n_done), 64'd0);
        run_op(8, 1'b0, 16'd2, 16'd2, 1'b0, s, co, ov, lat, bc);
        check("after abort sum", 64'(s), 64'h04);
        check("after abort latency", 64'(lat), 64'd9);

        // WIDTH=1 exhaustive full-adder truth table.
        for (int i = 0; i < 8; i++) begin
            logic ta, tb, tc;
            ta = (i & 4) != 0;
            tb = (i & 2) != 0;
            tc = (i & 1) != 0;
            run_op(1, 1'b0, 16'(ta), 16'(tb), tc, s, co, ov, lat, bc);
            eco = (ta & tb) | (ta & tc) | (tb & tc);
            check($sformatf("w1 %0d sum", i),  64'(s[0]), 64'(ta ^ tb ^ tc));
            check($sformatf("w1 %0d cout", i), 64'(co), 64'(eco));
            check($sformatf("w1 %0d ovf", i),  64'(ov), 64'(tc ^ eco));
            check($sformatf("w1 %0d latency", i), 64'(lat), 64'd2);
        end

        // WIDTH=16 random add/sub against the arithmetic model.
        for (int i = 0; i < 1000; i++) begin
            logic        rop, rc;
            logic [15:0] ra, rb;
            rop = 1'($urandom_range(1, 0));
            rc  = 1'($urandom_range(1, 0));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            run_op(16, rop, ra, rb, rc, s, co, ov, lat, bc);
            ref_model(16, rop, ra, rb, rc, es, eco, eov);
            check($sformatf("w16 %0d sum", i),  64'(s),  64'(es));
            check($sformatf("w16 %0d cout", i), 64'(co), 64'(eco));
            check($sformatf("w16 %0d ovf", i),  64'(ov), 64'(eov));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
